// File: rtl/cal_field_counter.sv
// Parametrised calendar field counter (day/month/year) with run/set modes,
// limit clamping and a sequential double-dabble BCD image of the count.
module cal_field_counter #(
  parameter int WIDTH      = 5,
  parameter int MIN_VAL    = 1,
  parameter int BCD_DIGITS = 2
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    set_mode,
  input  logic                    inc_key,
  input  logic                    dec_key,
  input  logic [WIDTH-1:0]        limit,
  output logic [WIDTH-1:0]        count,
  output logic                    carry,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam int BW = 4 * BCD_DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  logic [WIDTH-1:0] eff_lim;
  logic [1:0]       inc_sync, dec_sync;
  logic             inc_prev, dec_prev;
  logic             inc_edge, dec_edge;

  // A zero-based field can never see a limit below its minimum.
  generate
    if (MIN_VAL == 0) begin : g_zero_min
      assign eff_lim = limit;
    end else begin : g_pos_min
      assign eff_lim = (limit < MIN_V) ? MIN_V : limit;
    end
  endgenerate

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      inc_sync <= 2'b00;
      dec_sync <= 2'b00;
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      inc_sync <= {inc_sync[0], inc_key};
      dec_sync <= {dec_sync[0], dec_key};
      inc_prev <= inc_sync[1];
      dec_prev <= dec_sync[1];
    end
  end

  assign inc_edge = inc_sync[1] & ~inc_prev;
  assign dec_edge = dec_sync[1] & ~dec_prev;

  // Clamp outranks every event, so a shrinking limit always wins that cycle.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      count <= MIN_V;
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (count > eff_lim) begin
        count <= eff_lim;
      end else if (!set_mode) begin
        if (tick) begin
          if (count >= eff_lim) begin
            count <= MIN_V;
            carry <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
      end else if (inc_edge ^ dec_edge) begin
        if (inc_edge) begin
          count <= (count >= eff_lim) ? MIN_V : count + WIDTH'(1);
        end else begin
          count <= (count == MIN_V) ? eff_lim : count - WIDTH'(1);
        end
      end
    end
  end

  conv_state_t      state;
  logic [WIDTH-1:0] shadow;
  logic [SW-1:0]    shreg;
  logic [SW-1:0]    next_shreg;
  logic [CW-1:0]    bit_cnt;
  logic             started;
  logic             trigger;

  assign trigger = !started || (count != shadow);

  always_comb begin
    logic [SW-1:0] tmp;
    tmp = shreg;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (tmp[WIDTH+4*i +: 4] >= 4'd5) begin
        tmp[WIDTH+4*i +: 4] = tmp[WIDTH+4*i +: 4] + 4'd3;
      end
    end
    next_shreg = tmp << 1;
  end

  // A new trigger always restarts from SHIFT; bcd_out only moves in DONE.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shadow    <= MIN_V;
      shreg     <= '0;
      bit_cnt   <= '0;
      started   <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else if (trigger) begin
      started   <= 1'b1;
      shadow    <= count;
      shreg     <= {{BW{1'b0}}, count};
      bit_cnt   <= '0;
      bcd_valid <= 1'b0;
      state     <= SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          shreg   <= next_shreg;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_out   <= shreg[SW-1 -: BW];
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_field_counter.sv
// Self-checking bench for cal_field_counter: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the field.
module tb_cal_field_counter;

  localparam int WIDTH = 5;

  logic       clock_in = 1'b0;
  logic       reset;
  logic       tick, set_mode, inc_key, dec_key;
  logic [4:0] limit;
  logic [4:0] count;
  logic       carry;
  logic [7:0] bcd_out;
  logic       bcd_valid;

  logic       tick0;
  logic [4:0] limit0;
  logic [4:0] count0;
  logic       carry0;
  logic [7:0] bcd0;
  logic       bcd_valid0;

  int checks = 0;
  int errors = 0;

  cal_field_counter #(.WIDTH(5), .MIN_VAL(1), .BCD_DIGITS(2)) dut (
    .clock_in(clock_in), .reset(reset), .tick(tick), .set_mode(set_mode),
    .inc_key(inc_key), .dec_key(dec_key), .limit(limit), .count(count),
    .carry(carry), .bcd_out(bcd_out), .bcd_valid(bcd_valid)
  );

  cal_field_counter #(.WIDTH(5), .MIN_VAL(0), .BCD_DIGITS(2)) dut0 (
    .clock_in(clock_in), .reset(reset), .tick(tick0), .set_mode(1'b0),
    .inc_key(1'b0), .dec_key(1'b0), .limit(limit0), .count(count0),
    .carry(carry0), .bcd_out(bcd0), .bcd_valid(bcd_valid0)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model state (MIN_VAL = 1 instance).
  int       m_count;
  bit       m_carry;
  bit [7:0] m_bcd;
  bit       m_valid;
  int       m_cd;
  bit       m_chg_prev;
  bit       inc_h[3];
  bit       dec_h[3];

  function automatic bit [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_count    = 1;
    m_carry    = 0;
    m_bcd      = 8'h00;
    m_valid    = 0;
    m_cd       = 0;
    m_chg_prev = 1;
    for (int i = 0; i < 3; i++) begin
      inc_h[i] = 0;
      dec_h[i] = 0;
    end
  endtask

  // Field rules at one clock edge: keys act two edges after being sampled,
  // set-mode steps wrap modulo the span MIN..limit.
  task automatic model_edge();
    int  eff, span, old;
    bit  inc_ev, dec_ev;
    eff  = (int'(limit) < 1) ? 1 : int'(limit);
    span = eff;
    old  = m_count;
    if (m_chg_prev) begin
      m_valid = 0;
      m_cd    = WIDTH + 1;
    end else if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_valid = 1;
        m_bcd   = to_bcd(old);
      end
    end
    inc_ev   = inc_h[1] && !inc_h[2];
    dec_ev   = dec_h[1] && !dec_h[2];
    inc_h[2] = inc_h[1]; inc_h[1] = inc_h[0]; inc_h[0] = inc_key;
    dec_h[2] = dec_h[1]; dec_h[1] = dec_h[0]; dec_h[0] = dec_key;
    m_carry = 0;
    if (old > eff) begin
      m_count = eff;
    end else if (!set_mode) begin
      if (tick) begin
        if (old >= eff) begin
          m_count = 1;
          m_carry = 1;
        end else begin
          m_count = old + 1;
        end
      end
    end else if (inc_ev != dec_ev) begin
      if (inc_ev) m_count = 1 + ((old - 1 + 1) % span);
      else        m_count = 1 + ((old - 1 + span - 1) % span);
    end
    m_chg_prev = (m_count != old);
  endtask

  task automatic step();
    @(posedge clock_in);
    if (!reset) model_reset();
    else        model_edge();
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    step();
    step();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL reset_count got=%0d exp=1", count); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry); end
    checks++; if (bcd_out !== 8'h00 || bcd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_bcd got=%h/%b exp=00/0", bcd_out, bcd_valid);
    end
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (bcd_valid !== (k == 7)) begin
        errors++; $display("FAIL reset_latency cycle=%0d valid=%b exp=%b", k, bcd_valid, k == 7);
      end
    end
    checks++; if (bcd_out !== 8'h01) begin errors++; $display("FAIL reset_bcd_out got=%h exp=01", bcd_out); end
  endtask

  task automatic test_run_wrap();
    int guard = 0;
    limit = 5'd31;
    set_mode = 1'b0;
    while (m_count != 30 && guard < 64) begin
      pulse_tick();
      guard++;
    end
    checks++; if (count !== 5'd30) begin errors++; $display("FAIL run_reach30 got=%0d exp=30", count); end
    pulse_tick();
    checks++; if (count !== 5'd31 || carry !== 1'b0) begin
      errors++; $display("FAIL run_to31 got=%0d/%b exp=31/0", count, carry);
    end
    pulse_tick();
    checks++; if (count !== 5'd1 || carry !== 1'b1) begin
      errors++; $display("FAIL run_wrap got=%0d/%b exp=1/1", count, carry);
    end
    step();
    checks++; if (count !== 5'd1 || carry !== 1'b0) begin
      errors++; $display("FAIL run_carry_drop got=%0d/%b exp=1/0", count, carry);
    end
  endtask

  task automatic test_clamp();
    int guard = 0;
    while (m_count != 31 && guard < 64) begin
      pulse_tick();
      guard++;
    end
    limit = 5'd28;
    pulse_tick();
    checks++; if (count !== 5'd28 || carry !== 1'b0) begin
      errors++; $display("FAIL clamp got=%0d/%b exp=28/0", count, carry);
    end
    step();
    checks++; if (count !== 5'd28) begin errors++; $display("FAIL clamp_hold got=%0d exp=28", count); end
  endtask

  task automatic test_bcd();
    int guard = 0;
    limit = 5'd31;
    while (!m_valid && guard < 20) begin
      step();
      guard++;
    end
    checks++; if (bcd_valid !== 1'b1 || bcd_out !== 8'h28) begin
      errors++; $display("FAIL bcd_28 got=%h/%b exp=28/1", bcd_out, bcd_valid);
    end
    pulse_tick();
    checks++; if (count !== 5'd29) begin errors++; $display("FAIL bcd_count29 got=%0d exp=29", count); end
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (bcd_valid !== (k == 7)) begin
        errors++; $display("FAIL bcd_latency cycle=%0d valid=%b exp=%b", k, bcd_valid, k == 7);
      end
      if (k == 3) begin
        checks++; if (bcd_out !== 8'h28) begin errors++; $display("FAIL bcd_hold got=%h exp=28", bcd_out); end
      end
    end
    checks++; if (bcd_out !== 8'h29) begin errors++; $display("FAIL bcd_29 got=%h exp=29", bcd_out); end
    pulse_tick();
    for (int k = 0; k < 3; k++) step();
    pulse_tick();
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (bcd_valid !== (k == 7)) begin
        errors++; $display("FAIL bcd_restart cycle=%0d valid=%b exp=%b", k, bcd_valid, k == 7);
      end
    end
    checks++; if (bcd_out !== 8'h31) begin errors++; $display("FAIL bcd_31 got=%h exp=31", bcd_out); end
  endtask

  task automatic test_set_wrap();
    limit = 5'd30;
    step();
    checks++; if (count !== 5'd30) begin errors++; $display("FAIL set_clamp30 got=%0d exp=30", count); end
    pulse_tick();
    checks++; if (count !== 5'd1 || carry !== 1'b1) begin
      errors++; $display("FAIL set_prep got=%0d/%b exp=1/1", count, carry);
    end
    set_mode = 1'b1;
    dec_key  = 1'b1;
    step();
    dec_key  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL set_carry got=%b exp=0", carry); end
    end
    checks++; if (count !== 5'd30) begin errors++; $display("FAIL set_dec_wrap got=%0d exp=30", count); end
    inc_key = 1'b1;
    step();
    inc_key = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL set_inc_wrap got=%0d exp=1", count); end
  endtask

  task automatic test_keys();
    inc_key = 1'b1;
    for (int k = 0; k < 20; k++) step();
    inc_key = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL key_hold got=%0d exp=2", count); end
    inc_key = 1'b1;
    dec_key = 1'b1;
    for (int k = 0; k < 4; k++) step();
    inc_key = 1'b0;
    dec_key = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL key_both got=%0d exp=2", count); end
    for (int k = 0; k < 5; k++) begin
      pulse_tick();
      step();
    end
    checks++; if (count !== 5'd2 || carry !== 1'b0) begin
      errors++; $display("FAIL tick_in_set got=%0d/%b exp=2/0", count, carry);
    end
  endtask

  task automatic test_reset_mid();
    inc_key = 1'b1;
    step();
    inc_key = 1'b0;
    step();
    step();
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL mid_prep got=%0d exp=3", count); end
    for (int k = 0; k < 3; k++) step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (count !== 5'd1 || carry !== 1'b0 || bcd_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%0d/%b/%b exp=1/0/0", count, carry, bcd_valid);
    end
    step();
    step();
    set_mode = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (bcd_valid !== (k == 7)) begin
        errors++; $display("FAIL mid_relatency cycle=%0d valid=%b exp=%b", k, bcd_valid, k == 7);
      end
    end
    checks++; if (bcd_out !== 8'h01) begin errors++; $display("FAIL mid_bcd got=%h exp=01", bcd_out); end
  endtask

  task automatic test_zero_min();
    limit0 = 5'd0;
    for (int k = 0; k < 3; k++) begin
      tick0 = 1'b1;
      step();
      tick0 = 1'b0;
      checks++; if (count0 !== 5'd0 || carry0 !== 1'b1) begin
        errors++; $display("FAIL zero_tick got=%0d/%b exp=0/1", count0, carry0);
      end
      step();
      checks++; if (carry0 !== 1'b0) begin errors++; $display("FAIL zero_carry_drop got=%b exp=0", carry0); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 3) == 0) inc_key = ~inc_key;
      if ($urandom_range(0, 3) == 0) dec_key = ~dec_key;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) limit = 5'($urandom_range(0, 31));
        else                           limit = 5'($urandom_range(28, 31));
      end
      step();
      checks++; if (count !== 5'(m_count) || carry !== m_carry) begin
        errors++; $display("FAIL rand_count n=%0d got=%0d/%b exp=%0d/%b", n, count, carry, m_count, m_carry);
      end
      checks++; if (bcd_valid !== m_valid || bcd_out !== m_bcd) begin
        errors++; $display("FAIL rand_bcd n=%0d got=%h/%b exp=%h/%b", n, bcd_out, bcd_valid, m_bcd, m_valid);
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    tick     = 1'b0;
    set_mode = 1'b0;
    inc_key  = 1'b0;
    dec_key  = 1'b0;
    limit    = 5'd31;
    tick0    = 1'b0;
    limit0   = 5'd0;
    test_reset();
    test_run_wrap();
    test_clamp();
    test_bcd();
    test_set_wrap();
    test_keys();
    test_reset_mid();
    test_zero_min();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
